dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Arbitrates the single read/write port of the data memory between two requesters:
  - the pipeline memory stage (single-beat loads/stores);
  - an external host bulk-transfer engine fed through GPIO (multi-beat bursts).
- Sits between the memory stage and the data memory.
- Stalls the pipeline while the host owns the port.
- Guarantees bounded host waiting through a starvation counter.

Parameters:
- ADDR_W, 20, memory word address width.
- DATA_W, 24, memory data width.
- LEN_W, 5, burst length field width; maximum burst is 16 beats.
- STARVE_LIMIT, 8, number of cycles a pending host request may lose to the CPU before it is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  memory stage requests a load or store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  hold pipeline and memory-stage buffer; the CPU must keep cpu_* stable while this is high.
- cpu_rdata  out  DATA_W  load data; equals mem_rdata.
- host_req  in  1  host burst request; held high until host_done.
- host_we  in  1  burst direction, 1 = write.
- host_addr  in  ADDR_W  burst start address.
- host_len  in  LEN_W  number of beats, 1..16; 0 and values above 16 are treated as 1 and 16.
- host_wdata  in  DATA_W  current write beat; must advance on the cycle after host_beat_ack.
- host_beat_ack  out  1  beat issued to memory this cycle.
- host_rdata  out  DATA_W  read beat data.
- host_rvalid  out  1  host_rdata valid.
- host_done  out  1  one-cycle pulse at burst completion.
- host_busy  out  1  host owns the port.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the address (registered read).

Behaviour:
- States: IDLE, HOST_BURST, HOST_DRAIN.
- Reset: state = IDLE; beat_cnt = 0, len_reg = 0, starve_cnt = 0. Registered outputs (host_beat_ack, host_rvalid, host_done, host_busy) are 0.
- Combinational outputs in IDLE with no requests:
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_stall = 0.
  - host_rdata = 0 and cpu_rdata = 0 while rst is low.
- Arbitration happens only in IDLE:
  - host_win = host_req && (!cpu_req || starve_cnt == STARVE_LIMIT).
- CPU granted (IDLE, cpu_req, !host_win):
  - Pass-through: mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata, cpu_stall = 0, zero added latency.
  - Load data returns on mem_rdata / cpu_rdata the next cycle, as it does without the arbiter.
- Starvation counter:
  - starve_cnt++ (saturating at STARVE_LIMIT) on each IDLE cycle where host_req && cpu_req && !host_win.
  - Cleared on host grant.
  - Holds otherwise.
- Host grant (IDLE, host_win):
  - Latch host_addr, host_we, and the clamped host_len into len_reg.
  - Go to HOST_BURST next cycle; host_busy = 1 from that cycle on.
  - cpu_stall = cpu_req in the grant cycle and in every non-IDLE cycle.
- HOST_BURST, each cycle:
  - mem_addr = base + beat_cnt (mod 2^ADDR_W, wraps 0xFFFFF -> 0x00000).
  - mem_we = latched we; mem_wdata = host_wdata; host_beat_ack = 1; beat_cnt++.
- HOST_BURST exit on the last beat (beat_cnt == len_reg - 1):
  - Write burst: next state IDLE; host_done = 1 and host_busy = 0 in the following cycle.
  - Read burst: next state HOST_DRAIN.
- Read bursts:
  - host_rvalid = 1 and host_rdata = mem_rdata in the cycle after each read beat.
  - HOST_DRAIN lasts 1 cycle. It carries the final rvalid with host_done = 1, then goes to IDLE.
- Bursts are never preempted. host_req dropping mid-burst is ignored.
- No back-to-back bursts: the first cycle back in IDLE (the host_done cycle) ignores host_req, so a held host_req re-arbitrates one cycle later.
- Asynchronous reset mid-burst: immediate return to IDLE; all counters are cleared; no host_done is generated.

Test Plan:
- CPU only: store 0x123456 @0x00010, then load @0x00010 -> cpu_stall = 0 throughout; mem_we = 1 then 0; cpu_rdata = 0x123456 the cycle after the load address.
- Host write burst, len = 4 @0x00100 with data A,B,C,D -> host_beat_ack for 4 cycles; mem_addr 0x100..0x103; host_done one cycle after the last beat; a CPU load @0x102 afterwards returns C.
- Host read burst, len = 3 with cpu_req held high -> cpu_stall = 1 for all burst/drain cycles; 3 host_rvalid pulses, each 1 cycle after its beat; host_done coincides with the 3rd rvalid.
- Starvation: cpu_req and host_req both held high -> CPU granted for exactly 8 cycles, host granted on the 9th; starve_cnt = 0 after grant.
- Wrap and clamp: host_addr = 0xFFFFE, host_len = 0 then 31 -> 1 beat; then 16 beats with addresses 0xFFFFE, 0xFFFFF, 0x00000..0x0000D.
- rst low during beat 2 of a len = 8 write burst -> state IDLE, host_busy = 0, no host_done, cpu_stall = 0 next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single read/write port of the data memory between the pipeline
// memory stage (single-beat loads/stores) and a host bulk-transfer engine
// (bursts of 1..16 beats). The CPU passes straight through with no added
// latency. While the host owns the port, the CPU is stalled. A starvation
// counter bounds how long a pending host request can lose to the CPU.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  memory-stage request (held stable while cpu_stall)
//   cpu_stall          hold the pipeline this cycle
//   cpu_rdata          load data, one cycle after the load address
//   host_req/we/addr/len/wdata  host burst request, held until host_done
//   host_beat_ack      a host beat is issued to memory this cycle
//   host_rdata/rvalid  read-burst beat data, one cycle after each beat
//   host_done          one-cycle pulse at burst completion
//   host_busy          host owns the port
//   mem_we/addr/wdata  memory request
//   mem_rdata          memory read data (registered read, one-cycle latency)
module dmem_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 24,
  parameter int LEN_W        = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [LEN_W-1:0]  host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_beat_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_done,
  output logic              host_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW        = $clog2(STARVE_LIMIT + 1);
  localparam int MAX_BEATS = 16;

  typedef enum logic [1:0] {IDLE, HOST_BURST, HOST_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beatCnt;
  logic [SW-1:0]     r_starveCnt;
  logic              r_beatAck;
  logic              r_rvalid;
  logic              r_done;
  logic              r_busy;
  logic              r_cooldown;

  logic              w_hostReq;
  logic              w_starved;
  logic              w_hostWin;
  logic              w_cpuGrant;
  logic              w_lastBeat;
  logic [LEN_W-1:0]  w_lenClamp;

  // The first IDLE cycle after a burst ignores host_req, so a host still
  // holding its request while it sees host_done cannot grab a second burst.
  assign w_hostReq  = host_req && !r_cooldown;
  assign w_starved  = (r_starveCnt == SW'(STARVE_LIMIT));
  assign w_hostWin  = (r_state == IDLE) && w_hostReq && (!cpu_req || w_starved);
  assign w_cpuGrant = (r_state == IDLE) && cpu_req && !w_hostWin;
  assign w_lastBeat = (r_state == HOST_BURST) && (r_beatCnt == r_len - LEN_W'(1));

  // Zero-length requests become one beat; oversized requests become the maximum.
  always_comb begin
    w_lenClamp = host_len;
    if (host_len == '0)
      w_lenClamp = LEN_W'(1);
    else if (host_len > LEN_W'(MAX_BEATS))
      w_lenClamp = LEN_W'(MAX_BEATS);
  end

  // Read data is shared by both requesters and forced to zero during reset.
  assign cpu_rdata  = rst ? mem_rdata : '0;
  assign host_rdata = rst ? mem_rdata : '0;

  assign host_beat_ack = r_beatAck;
  assign host_rvalid   = r_rvalid;
  assign host_done     = r_done;
  assign host_busy     = r_busy;

  // Memory port steering and CPU stall.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    if (r_state == IDLE) begin
      if (w_cpuGrant) begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else if (w_hostWin) begin
        cpu_stall = cpu_req;
      end
    end else begin
      cpu_stall = cpu_req;
      if (r_state == HOST_BURST) begin
        mem_we    = r_we;
        mem_addr  = r_base + ADDR_W'(r_beatCnt);
        mem_wdata = host_wdata;
      end
    end
  end

  // Arbitration FSM. Registered host outputs are computed for the next cycle:
  // beat_ack tracks HOST_BURST occupancy, rvalid trails each read beat, and
  // done is raised after the last beat (IDLE for writes, DRAIN for reads).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_we        <= 1'b0;
      r_len       <= '0;
      r_beatCnt   <= '0;
      r_starveCnt <= '0;
      r_beatAck   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cooldown  <= 1'b0;
    end else begin
      r_beatAck  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_done     <= 1'b0;
      r_cooldown <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hostWin) begin
            r_state     <= HOST_BURST;
            r_base      <= host_addr;
            r_we        <= host_we;
            r_len       <= w_lenClamp;
            r_beatCnt   <= '0;
            r_starveCnt <= '0;
            r_busy      <= 1'b1;
            r_beatAck   <= 1'b1;
          end else if (w_hostReq && cpu_req && !w_starved) begin
            r_starveCnt <= r_starveCnt + SW'(1);
          end
        end
        HOST_BURST: begin
          r_rvalid <= !r_we;
          if (w_lastBeat) begin
            r_done    <= 1'b1;
            r_beatCnt <= '0;
            if (r_we) begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_cooldown <= 1'b1;
            end else begin
              r_state <= HOST_DRAIN;
            end
          end else begin
            r_beatCnt <= r_beatCnt + LEN_W'(1);
            r_beatAck <= 1'b1;
          end
        end
        HOST_DRAIN: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_cooldown <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter with a registered-read memory model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_stall;
  logic [23:0] cpu_rdata;
  logic        host_req;
  logic        host_we;
  logic [19:0] host_addr;
  logic [4:0]  host_len;
  logic [23:0] host_wdata;
  logic        host_beat_ack;
  logic [23:0] host_rdata;
  logic        host_rvalid;
  logic        host_done;
  logic        host_busy;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  int checkCount = 0;
  int failCount  = 0;

  logic [23:0] memArr [logic [19:0]];
  logic [23:0] burstData [4];

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_beat_ack(host_beat_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_done(host_done), .host_busy(host_busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock generation, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory model: registered read of the old contents, then write.
  always @(posedge clk) begin
    mem_rdata <= memArr.exists(mem_addr) ? memArr[mem_addr] : 24'h0;
    if (mem_we) memArr[mem_addr] = mem_wdata;
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive all requester inputs at the falling edge, then let them settle.
  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [19:0] cAddr,
                               input logic [23:0] cWd, input logic hReq, input logic hWe,
                               input logic [19:0] hAddr, input logic [4:0] hLen,
                               input logic [23:0] hWd);
    @(negedge clk);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWd;
    host_req = hReq; host_we = hWe; host_addr = hAddr; host_len = hLen; host_wdata = hWd;
    #1;
  endtask

  initial begin
    mem_rdata = 24'h0;
    burstData[0] = 24'hAAAA01; burstData[1] = 24'hBBBB02;
    burstData[2] = 24'hCCCC03; burstData[3] = 24'hDDDD04;
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_len = '0; host_wdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ack",   host_beat_ack, 0);
    checkOutput("rst_rvalid", host_rvalid, 0);
    checkOutput("rst_done",  host_done, 0);
    checkOutput("rst_busy",  host_busy, 0);
    checkOutput("rst_memwe", mem_we, 0);
    checkOutput("rst_addr",  mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_stall", cpu_stall, 0);
    checkOutput("rst_crd",   cpu_rdata, 0);
    checkOutput("rst_hrd",   host_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // CPU-only store then load.
    applyStimulus(1, 1, 20'h00010, 24'h123456, 0, 0, 0, 0, 0);
    checkOutput("cpu_st_we",    mem_we, 1);
    checkOutput("cpu_st_addr",  mem_addr, 32'h10);
    checkOutput("cpu_st_wdata", mem_wdata, 32'h123456);
    checkOutput("cpu_st_stall", cpu_stall, 0);
    applyStimulus(1, 0, 20'h00010, 24'h0, 0, 0, 0, 0, 0);
    checkOutput("cpu_ld_we",    mem_we, 0);
    checkOutput("cpu_ld_addr",  mem_addr, 32'h10);
    checkOutput("cpu_ld_stall", cpu_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cpu_ld_rdata", cpu_rdata, 32'h123456);

    // Host write burst, 4 beats at 0x100.
    applyStimulus(0, 0, 0, 0, 1, 1, 20'h00100, 5'd4, burstData[0]);
    checkOutput("hw_grant_memwe", mem_we, 0);
    checkOutput("hw_grant_busy",  host_busy, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 20'h00100, 5'd4, burstData[i]);
      checkOutput("hw_ack",   host_beat_ack, 1);
      checkOutput("hw_we",    mem_we, 1);
      checkOutput("hw_addr",  mem_addr, 32'h100 + 32'(i));
      checkOutput("hw_wdata", mem_wdata, 32'(burstData[i]));
      checkOutput("hw_busy",  host_busy, 1);
      checkOutput("hw_done",  host_done, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 20'h00100, 5'd4, 0);
    checkOutput("hw_done_pulse", host_done, 1);
    checkOutput("hw_done_busy",  host_busy, 0);
    checkOutput("hw_done_ack",   host_beat_ack, 0);
    checkOutput("hw_done_memwe", mem_we, 0);
    applyStimulus(1, 0, 20'h00102, 0, 0, 0, 0, 0, 0);
    checkOutput("hw_no_regrant", host_busy, 0);
    checkOutput("hw_done_clear", host_done, 0);
    checkOutput("hw_ld_addr",    mem_addr, 32'h102);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hw_ld_rdata",   cpu_rdata, 32'(burstData[2]));

    // Host read burst, 3 beats at 0x100, CPU requesting throughout.
    applyStimulus(0, 0, 0, 0, 1, 0, 20'h00100, 5'd3, 0);
    checkOutput("hr_grant_stall", cpu_stall, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 20'h00200, 0, 1, 0, 20'h00100, 5'd3, 0);
      checkOutput("hr_ack",   host_beat_ack, 1);
      checkOutput("hr_we",    mem_we, 0);
      checkOutput("hr_addr",  mem_addr, 32'h100 + 32'(i));
      checkOutput("hr_stall", cpu_stall, 1);
      checkOutput("hr_done",  host_done, 0);
      checkOutput("hr_rvalid", host_rvalid, (i == 0) ? 0 : 1);
      if (i > 0) checkOutput("hr_rdata", host_rdata, 32'(burstData[i-1]));
    end
    applyStimulus(1, 0, 20'h00200, 0, 1, 0, 20'h00100, 5'd3, 0);
    checkOutput("hr_drain_rvalid", host_rvalid, 1);
    checkOutput("hr_drain_rdata",  host_rdata, 32'(burstData[2]));
    checkOutput("hr_drain_done",   host_done, 1);
    checkOutput("hr_drain_stall",  cpu_stall, 1);
    checkOutput("hr_drain_ack",    host_beat_ack, 0);
    checkOutput("hr_drain_busy",   host_busy, 1);
    applyStimulus(1, 0, 20'h00200, 0, 0, 0, 0, 0, 0);
    checkOutput("hr_idle_stall",  cpu_stall, 0);
    checkOutput("hr_idle_rvalid", host_rvalid, 0);
    checkOutput("hr_idle_done",   host_done, 0);
    checkOutput("hr_idle_busy",   host_busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation: CPU wins 8 cycles, host wins the 9th.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 20'h00010, 0, 1, 1, 20'h00300, 5'd1, 24'h777777);
      checkOutput("sv_cpu_stall", cpu_stall, 0);
      checkOutput("sv_cpu_addr",  mem_addr, 32'h10);
    end
    applyStimulus(1, 0, 20'h00010, 0, 1, 1, 20'h00300, 5'd1, 24'h777777);
    checkOutput("sv_grant_stall", cpu_stall, 1);
    checkOutput("sv_grant_memwe", mem_we, 0);
    applyStimulus(1, 0, 20'h00010, 0, 1, 1, 20'h00300, 5'd1, 24'h777777);
    checkOutput("sv_beat_ack",   host_beat_ack, 1);
    checkOutput("sv_beat_addr",  mem_addr, 32'h300);
    checkOutput("sv_beat_stall", cpu_stall, 1);
    applyStimulus(1, 0, 20'h00010, 0, 1, 1, 20'h00300, 5'd1, 24'h777777);
    checkOutput("sv_done",       host_done, 1);
    checkOutput("sv_done_stall", cpu_stall, 0);
    applyStimulus(1, 0, 20'h00010, 0, 1, 1, 20'h00300, 5'd1, 24'h777777);
    checkOutput("sv_cleared_stall", cpu_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clamp and wrap: len 0 gives one beat, len 31 gives 16 beats.
    applyStimulus(0, 0, 0, 0, 1, 1, 20'hFFFFE, 5'd0, 24'h111111);
    applyStimulus(0, 0, 0, 0, 1, 1, 20'hFFFFE, 5'd0, 24'h111111);
    checkOutput("cl0_ack",  host_beat_ack, 1);
    checkOutput("cl0_addr", mem_addr, 32'hFFFFE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cl0_ack_end", host_beat_ack, 0);
    checkOutput("cl0_done",    host_done, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 20'hFFFFE, 5'd31, 24'h5A5A00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 20'hFFFFE, 5'd31, 24'h5A5A00 + 24'(i));
      checkOutput("cl31_ack",  host_beat_ack, 1);
      checkOutput("cl31_addr", mem_addr, 32'((20'hFFFFE + 20'(i)) & 20'hFFFFF));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cl31_ack_end", host_beat_ack, 0);
    checkOutput("cl31_done",    host_done, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during beat 2 of an 8-beat write burst.
    applyStimulus(0, 0, 0, 0, 1, 1, 20'h00400, 5'd8, 24'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 1, 1, 20'h00400, 5'd8, 24'h0);
    checkOutput("mr_beat2_addr", mem_addr, 32'h402);
    #2 rst = 1'b0;
    #1;
    checkOutput("mr_busy",  host_busy, 0);
    checkOutput("mr_ack",   host_beat_ack, 0);
    checkOutput("mr_memwe", mem_we, 0);
    checkOutput("mr_addr",  mem_addr, 0);
    @(negedge clk);
    #1;
    checkOutput("mr_crd_zero", cpu_rdata, 0);
    checkOutput("mr_hrd_zero", host_rdata, 0);
    checkOutput("mr_done",     host_done, 0);
    rst = 1'b1;
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00000;
    #1;
    checkOutput("mr_stall", cpu_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_done_after", host_done, 0);
    checkOutput("mr_busy_after", host_busy, 0);
    checkOutput("mr_cpu_rdata",  cpu_rdata, 32'h5A5A02);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
